// File: rtl/keypad_timer_if.sv
// Keypad encoder to timer decoder link: encoder-driven controls plus the
// BCD time and status returned to the display and magnetron logic.
interface keypad_timer_if;
  logic       en;
  logic [3:0] D;
  logic       load;
  logic       pgt_1Hz;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic       zero;
  logic       running;
  logic       done;
  logic       err;

  modport master (
    output en, D, load, pgt_1Hz,
    input  sec_ones, sec_tens, min_ones, zero, running, done, err
  );

  modport slave (
    input  en, D, load, pgt_1Hz,
    output sec_ones, sec_tens, min_ones, zero, running, done, err
  );
endinterface

// File: rtl/keypad_timer_decoder.sv
// Decodes keypad strobes into an M:SS BCD cook time and counts it down
// once per 1 Hz tick while the encoder holds the run mode.
module keypad_timer_decoder #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned SEC_TENS_MAX = 5
) (
  input  logic          clk,
  input  logic          clear,
  keypad_timer_if.slave kp
);
  localparam int unsigned DW = 4;

  typedef enum logic [1:0] {ST_ENTRY, ST_RUN, ST_HOLD, ST_DONE} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] load_sync_q, load_sync_d;
  logic [SYNC_STAGES-1:0] pgt_sync_q, pgt_sync_d;
  logic [SYNC_STAGES-1:0] en_sync_q, en_sync_d;
  logic                   pgt_prev_q, pgt_prev_d;
  logic                   en_prev_q, en_prev_d;
  logic [DW-1:0]          sec_ones_q, sec_ones_d;
  logic [DW-1:0]          sec_tens_q, sec_tens_d;
  logic [DW-1:0]          min_ones_q, min_ones_d;
  logic                   running_q, running_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic          load_s, pgt_s, en_s;
  logic          strb, en_rise, accept, tick;
  logic          digit_ok, shift_ok, zero_c, at_one;
  logic [DW-1:0] dec_ones, dec_tens, dec_min;

  assign load_s   = load_sync_q[SYNC_STAGES-1];
  assign pgt_s    = pgt_sync_q[SYNC_STAGES-1];
  assign en_s     = en_sync_q[SYNC_STAGES-1];
  assign strb     = pgt_s & ~pgt_prev_q;
  assign en_rise  = en_s & ~en_prev_q;
  assign accept   = strb & ~en_s & load_s;
  assign tick     = strb & en_s;
  assign digit_ok = (kp.D <= DW'(9));
  // The current units digit becomes the seconds-tens digit after a shift.
  assign shift_ok = (sec_ones_q <= DW'(SEC_TENS_MAX));
  assign zero_c   = (min_ones_q == '0) && (sec_tens_q == '0) && (sec_ones_q == '0);
  assign at_one   = (min_ones_q == '0) && (sec_tens_q == '0) && (sec_ones_q == DW'(1));

  // Synchroniser chains and edge-detect history
  always_comb begin
    load_sync_d = {load_sync_q[SYNC_STAGES-2:0], kp.load};
    pgt_sync_d  = {pgt_sync_q[SYNC_STAGES-2:0], kp.pgt_1Hz};
    en_sync_d   = {en_sync_q[SYNC_STAGES-2:0], kp.en};
    pgt_prev_d  = pgt_s;
    en_prev_d   = en_s;
  end

  // One-second decrement with borrow across tens and minutes
  always_comb begin
    dec_ones = sec_ones_q - DW'(1);
    dec_tens = sec_tens_q;
    dec_min  = min_ones_q;
    if (sec_ones_q == '0) begin
      dec_ones = DW'(9);
      if (sec_tens_q == '0) begin
        dec_tens = DW'(SEC_TENS_MAX);
        dec_min  = min_ones_q - DW'(1);
      end else begin
        dec_tens = sec_tens_q - DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= ST_ENTRY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ENTRY: if (en_rise && !zero_c) state_d = ST_RUN;
      ST_RUN: begin
        if (!en_s)                state_d = ST_HOLD;
        else if (tick && at_one)  state_d = ST_DONE;
      end
      ST_HOLD: begin
        if (en_rise)                  state_d = ST_RUN;
        else if (accept && digit_ok)  state_d = ST_ENTRY;
      end
      ST_DONE: if (accept && digit_ok) state_d = ST_ENTRY;
      default: state_d = ST_ENTRY;
    endcase
  end

  always_comb begin
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    running_d  = (state_d == ST_RUN);
    case (state_q)
      ST_ENTRY: begin
        if (accept) begin
          if (digit_ok && shift_ok) begin
            {min_ones_d, sec_tens_d, sec_ones_d} = {sec_tens_q, sec_ones_q, kp.D};
          end else begin
            err_d = 1'b1;
          end
        end
        if (en_rise && zero_c) err_d = 1'b1;
      end
      ST_RUN: begin
        // Dropping en wins over a coincident tick.
        if (en_s && tick) begin
          {min_ones_d, sec_tens_d, sec_ones_d} = {dec_min, dec_tens, dec_ones};
          done_d = at_one;
        end
      end
      ST_HOLD, ST_DONE: begin
        if (accept) begin
          if (digit_ok) begin
            {min_ones_d, sec_tens_d, sec_ones_d} = {DW'(0), DW'(0), kp.D};
          end else begin
            err_d = 1'b1;
          end
        end
        if (state_q == ST_DONE && en_rise) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      load_sync_q <= '0;
      pgt_sync_q  <= '0;
      en_sync_q   <= '0;
      pgt_prev_q  <= 1'b0;
      en_prev_q   <= 1'b0;
      sec_ones_q  <= '0;
      sec_tens_q  <= '0;
      min_ones_q  <= '0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      load_sync_q <= load_sync_d;
      pgt_sync_q  <= pgt_sync_d;
      en_sync_q   <= en_sync_d;
      pgt_prev_q  <= pgt_prev_d;
      en_prev_q   <= en_prev_d;
      sec_ones_q  <= sec_ones_d;
      sec_tens_q  <= sec_tens_d;
      min_ones_q  <= min_ones_d;
      running_q   <= running_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign kp.sec_ones = sec_ones_q;
  assign kp.sec_tens = sec_tens_q;
  assign kp.min_ones = min_ones_q;
  assign kp.zero     = zero_c;
  assign kp.running  = running_q;
  assign kp.done     = done_q;
  assign kp.err      = err_q;
endmodule
